// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the fetch and decode stages.
// Holds opcode constants, the fetch FSM state type and the instruction
// length rule, so both stages agree on 1- versus 2-byte encodings.
package cpu_isa_pkg;

  localparam int unsigned BYTE_W = 8;

  // Representative opcodes (register fields in the low bits are zero)
  localparam logic [BYTE_W-1:0] OP_NOP     = 8'h00;
  localparam logic [BYTE_W-1:0] OP_MOV_IMM = 8'h80;
  localparam logic [BYTE_W-1:0] OP_CMP_IMM = 8'h8C;
  localparam logic [BYTE_W-1:0] OP_OUTPUT  = 8'h9C;
  localparam logic [BYTE_W-1:0] OP_BEQ     = 8'hA0;
  localparam logic [BYTE_W-1:0] OP_BHI     = 8'hA4;
  localparam logic [BYTE_W-1:0] OP_BRA     = 8'hA8;

  typedef enum logic [1:0] {
    BYTE0 = 2'd0,
    BYTE1 = 2'd1,
    VALID = 2'd2
  } fetch_state_e;

  // Branches, MOV_IMM and CMP_IMM carry an immediate second byte
  function automatic logic is_two_byte(input logic [BYTE_W-1:0] b);
    return (b[7:5] == 3'b101) ||
           (b[7:2] == 6'b100000) ||
           (b[7:2] == 6'b100011);
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the program counter, reads the program ROM one
// byte per cycle, assembles 1- or 2-byte instructions and presents them to
// decode over a valid/ready handshake. Branch redirects restart fetch.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   address_bus       ROM byte address (equals pc)
//   data_bus          ROM byte at address_bus, same cycle
//   enable            0 freezes fetch progress
//   redirect_valid    branch taken; redirect_addr is the new pc
//   instr_valid       instr_* hold a complete instruction
//   instr_ready       decode accepts the instruction this cycle
//   instr_op/imm      first/second byte (imm = 0 for 1-byte instructions)
//   instr_len2        instruction is 2 bytes long
//   instr_pc          address of the first byte
module instruction_fetch
  import cpu_isa_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 8,
  parameter int unsigned        DATA_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] address_bus,
  input  logic [DATA_W-1:0] data_bus,
  input  logic              enable,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_op,
  output logic [DATA_W-1:0] instr_imm,
  output logic              instr_len2,
  output logic [ADDR_W-1:0] instr_pc
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              len2_q, len2_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BYTE0;
      pc_q    <= RESET_PC;
      ipc_q   <= '0;
      op_q    <= '0;
      imm_q   <= '0;
      len2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      len2_q  <= len2_d;
    end
  end

  // Next-state logic; a redirect overrides any fetch or handshake progress
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    op_d    = op_q;
    imm_d   = imm_q;
    len2_d  = len2_q;

    if (redirect_valid) begin
      pc_d    = redirect_addr;
      state_d = BYTE0;
    end else begin
      unique case (state_q)
        BYTE0: begin
          if (enable) begin
            op_d  = data_bus;
            ipc_d = pc_q;
            imm_d = '0;
            pc_d  = pc_q + ADDR_W'(1);
            if (is_two_byte(data_bus[7:0])) begin
              len2_d  = 1'b1;
              state_d = BYTE1;
            end else begin
              len2_d  = 1'b0;
              state_d = VALID;
            end
          end
        end
        BYTE1: begin
          if (enable) begin
            imm_d   = data_bus;
            pc_d    = pc_q + ADDR_W'(1);
            state_d = VALID;
          end
        end
        VALID: begin
          // Handshake completes regardless of enable
          if (instr_ready) begin
            state_d = BYTE0;
          end
        end
        default: state_d = BYTE0;
      endcase
    end
  end

  assign address_bus = pc_q;
  assign instr_valid = (state_q == VALID);
  assign instr_op    = op_q;
  assign instr_imm   = imm_q;
  assign instr_len2  = len2_q;
  assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal expectations,
// then randomized enable/ready/redirect/reset traffic checked every cycle
// against an instruction-stream model of the fetch unit.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] address_bus;
  logic [7:0] data_bus;
  logic       enable;
  logic       redirect_valid;
  logic [7:0] redirect_addr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_op;
  logic [7:0] instr_imm;
  logic       instr_len2;
  logic [7:0] instr_pc;

  logic [7:0] rom [256];
  int errors = 0;
  int checks = 0;

  // Model: address of the next instruction and fetch cycles spent on it
  logic [7:0] nia = 8'd0;
  int         cnt = 0;
  bit         model_ok = 1'b0;

  always #5 clk = ~clk;
  assign data_bus = rom[address_bus];

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .address_bus    (address_bus),
    .data_bus       (data_bus),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_op       (instr_op),
    .instr_imm      (instr_imm),
    .instr_len2     (instr_len2),
    .instr_pc       (instr_pc)
  );

  // Length rule written as opcode ranges
  function automatic int instr_len(input logic [7:0] b);
    if ((b >= 8'hA0 && b <= 8'hBF) || (b >= 8'h80 && b <= 8'h83) ||
        (b >= 8'h8C && b <= 8'h8F))
      return 2;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on the active edge using pre-edge values
  always @(posedge clk) begin
    int len;
    bit v;
    len = instr_len(rom[nia]);
    v   = (cnt >= len);
    if (reset) begin
      nia = 8'd0; cnt = 0; model_ok = 1'b1;
    end else if (redirect_valid) begin
      nia = redirect_addr; cnt = 0;
    end else if (v) begin
      if (instr_ready) begin nia = nia + 8'(len); cnt = 0; end
    end else if (enable) begin
      cnt++;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    int len;
    logic [7:0] op;
    if (model_ok && !reset) begin
      op  = rom[nia];
      len = instr_len(op);
      chk("address_bus", 32'(address_bus), 32'(8'(nia + 8'(cnt))));
      chk("instr_valid", 32'(instr_valid), 32'(cnt >= len));
      if (cnt >= len) begin
        chk("instr_op",   32'(instr_op),   32'(op));
        chk("instr_imm",  32'(instr_imm),  (len == 2) ? 32'(rom[8'(nia + 8'd1)]) : 32'd0);
        chk("instr_len2", 32'(instr_len2), 32'(len == 2));
        chk("instr_pc",   32'(instr_pc),   32'(nia));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 12 && !instr_valid; i++) step();
    chk("wait_valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  task automatic accept();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; redirect_valid = 1'b0;
    redirect_addr = 8'd0; instr_ready = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h82; rom[1] = 8'h00;
    for (int i = 2; i < 6; i++) rom[i] = 8'h00;
    rom[6] = 8'hB4; rom[7] = 8'hF7;
    rom[247] = 8'h9E; rom[248] = 8'h80; rom[249] = 8'h55;
    rom[255] = 8'hA8;

    step(); step();
    reset = 1'b0;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_op",    32'(instr_op),    32'd0);
    chk("rst_imm",   32'(instr_imm),   32'd0);
    chk("rst_len2",  32'(instr_len2),  32'd0);
    chk("rst_ipc",   32'(instr_pc),    32'd0);
    chk("rst_addr",  32'(address_bus), 32'd0);

    // 2-byte MOV_IMM at 0
    step();
    chk("t1_addr1",  32'(address_bus), 32'd1);
    chk("t1_valid0", 32'(instr_valid), 32'd0);
    step();
    chk("t1_addr2",  32'(address_bus), 32'd2);
    chk("t1_valid",  32'(instr_valid), 32'd1);
    chk("t1_op",     32'(instr_op),    32'h82);
    chk("t1_imm",    32'(instr_imm),   32'h00);
    chk("t1_len2",   32'(instr_len2),  32'd1);
    chk("t1_ipc",    32'(instr_pc),    32'd0);
    instr_ready = 1'b0;
    accept();
    for (int k = 0; k < 4; k++) begin wait_valid(); accept(); end

    // Back-pressure on the branch at 6
    wait_valid();
    chk("t3_ipc", 32'(instr_pc), 32'd6);
    chk("t3_op",  32'(instr_op), 32'hB4);
    chk("t3_imm", 32'(instr_imm), 32'hF7);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_hold_valid", 32'(instr_valid), 32'd1);
      chk("t3_hold_pc",    32'(address_bus), 32'd8);
      chk("t3_hold_op",    32'(instr_op),    32'hB4);
    end
    accept();

    // Redirect to a 1-byte instruction at 247
    redirect_valid = 1'b1; redirect_addr = 8'd247;
    step();
    redirect_valid = 1'b0;
    chk("t2_valid0", 32'(instr_valid), 32'd0);
    chk("t2_addr",   32'(address_bus), 32'd247);
    step();
    chk("t2_valid", 32'(instr_valid), 32'd1);
    chk("t2_op",    32'(instr_op),    32'h9E);
    chk("t2_imm",   32'(instr_imm),   32'h00);
    chk("t2_len2",  32'(instr_len2),  32'd0);
    chk("t2_ipc",   32'(instr_pc),    32'd247);
    accept();

    // Redirect while in the second byte of MOV_IMM at 248
    step();
    redirect_valid = 1'b1; redirect_addr = 8'hF8;
    step();
    redirect_valid = 1'b0;
    chk("t4_valid0", 32'(instr_valid), 32'd0);
    chk("t4_addr",   32'(address_bus), 32'hF8);
    wait_valid();
    chk("t4_ipc", 32'(instr_pc),  32'hF8);
    chk("t4_op",  32'(instr_op),  32'h80);
    chk("t4_imm", 32'(instr_imm), 32'h55);
    accept();

    // BRA at 255 with its immediate at 0
    rom[0] = 8'h04;
    redirect_valid = 1'b1; redirect_addr = 8'd255;
    step();
    redirect_valid = 1'b0;
    wait_valid();
    chk("t5_op",   32'(instr_op),    32'hA8);
    chk("t5_imm",  32'(instr_imm),   32'h04);
    chk("t5_ipc",  32'(instr_pc),    32'hFF);
    chk("t5_len2", 32'(instr_len2),  32'd1);
    chk("t5_addr", 32'(address_bus), 32'd1);
    accept();

    // Freeze in BYTE0, then reset in the middle of a 2-byte fetch
    enable = 1'b0;
    rom[1] = 8'h8C;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_addr",  32'(address_bus), 32'd1);
      chk("t6_valid", 32'(instr_valid), 32'd0);
    end
    enable = 1'b1;
    step();
    chk("t6_byte1_addr", 32'(address_bus), 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_valid", 32'(instr_valid), 32'd0);
    chk("t6_rst_op",    32'(instr_op),    32'd0);
    chk("t6_rst_imm",   32'(instr_imm),   32'd0);
    chk("t6_rst_len2",  32'(instr_len2),  32'd0);
    chk("t6_rst_ipc",   32'(instr_pc),    32'd0);
    chk("t6_rst_addr",  32'(address_bus), 32'd0);

    // Randomized traffic on a fresh ROM image
    reset = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    step();
    reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      enable         = ($urandom_range(0, 3) != 0);
      instr_ready    = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_addr  = 8'($urandom);
      reset          = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0; redirect_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name:
instruction_fetch

Overview:
- Reader side of the program-memory interface. Drives `address_bus` into the 256×8 program ROM and samples `data_bus` (combinational read, valid the same cycle).
- Assembles 1- or 2-byte instructions and hands them to the decode/execute stage over a valid/ready handshake.
- Accepts branch redirects from execute and owns the program counter (`pc`).

Parameters:
- ADDR_W, 8, program-memory address width; `pc` width.
- DATA_W, 8, instruction byte width.
- RESET_PC, 8'd0, `pc` value loaded on reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- address_bus  out  ADDR_W  byte address to program memory.
- data_bus  in  DATA_W  byte at `address_bus`, same cycle.
- enable  in  1  0 = freeze fetch: no `pc` advance, state held.
- redirect_valid  in  1  branch taken this cycle.
- redirect_addr  in  ADDR_W  branch target.
- instr_valid  out  1  `instr_*` outputs hold a complete instruction.
- instr_ready  in  1  decode accepts the instruction this cycle.
- instr_op  out  DATA_W  first byte (opcode/register fields).
- instr_imm  out  DATA_W  second byte; 0 for 1-byte instructions.
- instr_len2  out  1  1 = 2-byte instruction.
- instr_pc  out  ADDR_W  address of the first byte.

Behaviour:
- Reset (clk edge with reset=1):
  - `pc`=RESET_PC, state=BYTE0.
  - instr_valid=0, instr_op=0, instr_imm=0, instr_len2=0, instr_pc=0.
- `address_bus` = `pc` combinationally in all states.
- Length rule, evaluated on the first byte b:
  - 2-byte iff b[7:5]==3'b101 (branches), or b[7:2]==6'b100000 (MOV_IMM), or b[7:2]==6'b100011 (CMP_IMM).
  - Every other byte is a 1-byte instruction.
- FSM states: BYTE0, BYTE1, VALID.
  - BYTE0 (enable=1):
    - instr_op<=data_bus, instr_pc<=pc, instr_imm<=0, pc<=pc+1.
    - If 2-byte: instr_len2<=1, go to BYTE1.
    - Else: instr_len2<=0, go to VALID.
  - BYTE1 (enable=1): instr_imm<=data_bus, pc<=pc+1, go to VALID.
  - VALID: instr_valid=1.
    - instr_valid && instr_ready: go to BYTE0.
    - Otherwise hold; all `instr_*` outputs stay stable while instr_valid=1 and instr_ready=0.
- Latency and throughput:
  - 1-byte instruction: valid 1 cycle after entering BYTE0.
  - 2-byte instruction: valid 2 cycles after entering BYTE0.
  - Minimum issue period: 2 cycles for 1-byte, 3 cycles for 2-byte instructions.
- enable=0 in BYTE0/BYTE1: no register update.
- enable=0 in VALID: the handshake still completes, but the state moves to BYTE0 and then waits there.
- Redirect has priority over everything except reset, in every state:
  - pc<=redirect_addr, state<=BYTE0, instr_valid=0 next cycle.
  - Any partially fetched instruction is discarded.
  - If a handshake occurs in the same cycle, that instruction counts as consumed; the redirect still takes effect.
  - A redirect while enable=0 still loads `pc`.
- `pc` arithmetic is modulo 2^ADDR_W: 255+1 wraps to 0. A 2-byte instruction at 255 takes its immediate from address 0.
- Reset mid-instruction discards all partial state and restarts at RESET_PC.

Decomposition:
- Shared package `cpu_isa_pkg`:
  - opcode constants (MOV_IMM, CMP_IMM, BRA, BHI, BEQ, NOP, ...).
  - fetch state enum {BYTE0, BYTE1, VALID}.
  - function `is_two_byte(byte)` implementing the length rule, reused by the decoder.
- No sub-module. The FSM and `pc` stay in `instruction_fetch`.

Test Plan:
- Reset, then ROM[0..1]=0x82,0x00, instr_ready=1 → instr_valid rises 2 cycles after reset release with op=0x82, imm=0x00, len2=1, instr_pc=0; `address_bus` shows 0,1,2.
- ROM[247]=0x9E (OUTPUT R2), redirect to 247 → next valid has op=0x9E, imm=0, len2=0, instr_pc=247 one cycle after entering BYTE0.
- ROM[6..7]=0xB4,0xF7, instr_ready=0 for 5 cycles → instr_valid stays 1 with outputs stable; `pc` stays 8; accepted when instr_ready=1.
- In BYTE1 of a 2-byte fetch, pulse redirect_valid with redirect_addr=0xF8 → partial instruction dropped, instr_valid=0, next instr_pc=0xF8.
- ROM[255]=0xA8 (BRA), ROM[0]=0x04 → op=0xA8, imm=0x04, instr_pc=255; `pc` wraps to 1 afterwards.
- enable=0 for 3 cycles in BYTE0 → `address_bus` is constant and instr_valid=0; reset asserted during BYTE1 → outputs cleared, `pc`=0.
